// File: rtl/distance_filter.sv
// Four-sample moving-average filter for ultrasonic range readings, with clamping and a stale-output timeout.
// Define DIST_FILTER_OUTLIER_EN to reject single out-of-range jumps until a second one confirms them.
module distance_filter #(
    parameter int MAX_CM         = 199,
    parameter int TIMEOUT_CYCLES = 75000000,
    parameter int OUTLIER_DELTA  = 40
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic [7:0] distance,
    output logic       distance_valid,
    output logic       stale
);

    localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  T_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [7:0]     S_MAX = 8'(MAX_CM);

    typedef enum logic [1:0] {EMPTY, TRACK, STALE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    w_q [4];
    logic [7:0]    w_d [4];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          upd_q, upd_d;
    logic [7:0]    dist_q, dist_d;
    logic          dv_q, dv_d;
    logic          stale_q, stale_d;

    logic [7:0]    s;
    logic [9:0]    sum;
    logic          timeout;
    logic          discard;
    logic          reload;

    always_comb begin
        s       = (sample > S_MAX) ? S_MAX : sample;
        sum     = {2'b00, w_q[0]} + {2'b00, w_q[1]} + {2'b00, w_q[2]} + {2'b00, w_q[3]};
        timeout = (cnt_q == T_MAX);
    end

`ifdef DIST_FILTER_OUTLIER_EN
    logic       pend_q, pend_d;
    logic [7:0] diff;
    logic       far;

    // The jump is measured against the published distance, not the window contents.
    always_comb begin
        diff    = (s >= dist_q) ? (s - dist_q) : (dist_q - s);
        far     = (int'(diff) > OUTLIER_DELTA);
        discard = sample_valid && (state_q == TRACK) && far && !pend_q;
        reload  = sample_valid && (state_q == TRACK) && far && pend_q;
        pend_d  = pend_q;
        if (sample_valid) begin
            pend_d = discard;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    always_comb begin
        discard = 1'b0;
        reload  = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upd_d   = 1'b0;
        dist_d  = dist_q;
        dv_d    = 1'b0;
        stale_d = stale_q;
        for (int i = 0; i < 4; i++) begin
            w_d[i] = w_q[i];
        end

        // A sample accepted last edge is published now from the updated window.
        if (upd_q) begin
            dist_d = 8'(sum >> 2);
            dv_d   = 1'b1;
        end

        if (sample_valid) begin
            cnt_d = '0;
            upd_d = 1'b1;
            if (state_q == TRACK && !reload) begin
                if (!discard) begin
                    w_d[0] = s;
                    for (int i = 1; i < 4; i++) begin
                        w_d[i] = w_q[i-1];
                    end
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    w_d[i] = s;
                end
                state_d = TRACK;
                stale_d = 1'b0;
            end
        end else begin
            if (!timeout) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (state_q == TRACK && timeout) begin
                state_d = STALE;
                stale_d = 1'b1;
                dist_d  = 8'd0;
                dv_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            dist_q  <= 8'd0;
            dv_q    <= 1'b0;
            stale_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            dist_q  <= dist_d;
            dv_q    <= dv_d;
            stale_q <= stale_d;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign distance       = dist_q;
    assign distance_valid = dv_q;
    assign stale          = stale_q;

endmodule

// File: tb/tb_distance_filter.sv
// Self-checking bench for distance_filter: directed scenarios plus random traffic against a queue-based model.
module tb_distance_filter;

    localparam int MAX_CM = 199;
    localparam int TMO    = 64;
    localparam int DELTA  = 40;

    logic       clock = 1'b0;
    logic       resetn;
    logic       sample_valid;
    logic [7:0] sample;
    logic [7:0] distance;
    logic       distance_valid;
    logic       stale;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    distance_filter #(
        .MAX_CM        (MAX_CM),
        .TIMEOUT_CYCLES(TMO),
        .OUTLIER_DELTA (DELTA)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .distance      (distance),
        .distance_valid(distance_valid),
        .stale         (stale)
    );

    // Reference: mode 0 = empty, 1 = tracking, 2 = stale; window holds the last four accepted readings.
    int m_mode;
    int m_win[$];
    int m_idle;
    bit m_pend;
    int m_dist;
    bit m_dv;
    bit m_stale;
    bit m_pub;
    int m_pubval;

    function automatic int win_avg();
        int total = 0;
        foreach (m_win[i]) total += m_win[i];
        return total / 4;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_win   = '{0, 0, 0, 0};
        m_idle  = 0;
        m_pend  = 0;
        m_dist  = 0;
        m_dv    = 0;
        m_stale = 0;
        m_pub   = 0;
        m_pubval = 0;
    endtask

    task automatic model_edge(input bit v, input int smp);
        int c;
        int old_dist;
        bit far;
        old_dist = m_dist;
        m_dv = 0;
        if (m_pub) begin
            m_dist = m_pubval;
            m_dv   = 1;
        end
        m_pub = 0;
        if (v) begin
            c = (smp > MAX_CM) ? MAX_CM : smp;
            far = ((c > old_dist) ? (c - old_dist) : (old_dist - c)) > DELTA;
            m_idle = 0;
            if (m_mode != 1) begin
                m_win   = '{c, c, c, c};
                m_mode  = 1;
                m_stale = 0;
                m_pend  = 0;
            end else begin
`ifdef DIST_FILTER_OUTLIER_EN
                if (far && !m_pend) begin
                    m_pend = 1;
                end else if (far) begin
                    m_win  = '{c, c, c, c};
                    m_pend = 0;
                end else begin
                    m_win.push_front(c);
                    void'(m_win.pop_back());
                    m_pend = 0;
                end
`else
                if (far || !far) begin
                    m_win.push_front(c);
                    void'(m_win.pop_back());
                end
`endif
            end
            m_pub    = 1;
            m_pubval = win_avg();
        end else begin
            if (m_mode == 1 && m_idle == TMO) begin
                m_mode  = 2;
                m_stale = 1;
                m_dist  = 0;
                m_dv    = 1;
            end
            if (m_idle < TMO) m_idle++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("distance", {24'd0, distance}, m_dist);
        chk("distance_valid", {31'd0, distance_valid}, {31'd0, m_dv});
        chk("stale", {31'd0, stale}, {31'd0, m_stale});
    endtask

    // Drive one cycle of input, let the DUT clock it, then compare on the falling edge.
    task automatic tick(input bit v, input int smp);
        sample_valid = v;
        sample       = smp[7:0];
        @(posedge clock);
        model_edge(v, smp);
        @(negedge clock);
        sample_valid = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(negedge clock);
        check_outputs();
        resetn = 1'b1;
    endtask

    initial begin
        int pulses;
        resetn       = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'd0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_distance", {24'd0, distance}, 0);
        chk("reset_dvalid", {31'd0, distance_valid}, 0);
        chk("reset_stale", {31'd0, stale}, 0);
        resetn = 1'b1;

        // Single reading, two-edge latency
        tick(1, 100);
        chk("first_no_early_pulse", {31'd0, distance_valid}, 0);
        tick(0, 0);
        chk("first_distance", {24'd0, distance}, 100);
        chk("first_dvalid", {31'd0, distance_valid}, 1);
        chk("first_stale", {31'd0, stale}, 0);
        tick(0, 0);
        chk("first_pulse_single", {31'd0, distance_valid}, 0);

        // Back-to-back readings, one pulse each in order
        tick(1, 100);
        tick(1, 104);
        chk("b2b_0", {24'd0, distance}, 100);
        tick(1, 108);
        chk("b2b_1", {24'd0, distance}, 101);
        tick(1, 112);
        chk("b2b_2", {24'd0, distance}, 103);
        tick(0, 0);
        chk("b2b_3", {24'd0, distance}, 106);
        chk("b2b_3_dv", {31'd0, distance_valid}, 1);

        // Clamp from a fresh start
        do_reset();
        tick(1, 250);
        tick(0, 0);
        chk("clamp_distance", {24'd0, distance}, 199);

        // Timeout to stale, then recovery
        tick(1, 50);
        pulses = 0;
        for (int i = 1; i <= TMO + 3; i++) begin
            tick(0, 0);
            if (distance_valid && stale) pulses++;
            if (i == TMO) chk("stale_not_early", {31'd0, stale}, 0);
            if (i == TMO + 1) begin
                chk("stale_set", {31'd0, stale}, 1);
                chk("stale_distance", {24'd0, distance}, 0);
                chk("stale_pulse", {31'd0, distance_valid}, 1);
            end
        end
        chk("stale_pulse_count", pulses, 1);
        tick(1, 30);
        chk("recover_stale_clear", {31'd0, stale}, 0);
        tick(0, 0);
        chk("recover_distance", {24'd0, distance}, 30);

        // Sample arriving exactly as the timeout expires
        tick(1, 60);
        for (int i = 0; i < TMO; i++) tick(0, 0);
        tick(1, 70);
        tick(0, 0);
        chk("race_stale_low", {31'd0, stale}, 0);
        tick(0, 0);
        chk("race_stale_low2", {31'd0, stale}, 0);

`ifdef DIST_FILTER_OUTLIER_EN
        do_reset();
        tick(1, 50);
        tick(0, 0);
        tick(1, 150);
        tick(0, 0);
        chk("outlier_hold", {24'd0, distance}, 50);
        chk("outlier_hold_dv", {31'd0, distance_valid}, 1);
        tick(1, 150);
        tick(0, 0);
        chk("outlier_confirm", {24'd0, distance}, 150);
        do_reset();
        tick(1, 50);
        tick(0, 0);
        tick(1, 150);
        tick(1, 55);
        tick(0, 0);
        chk("outlier_then_near", {24'd0, distance}, 51);
`endif

        // Asynchronous reset with an update in flight
        tick(1, 120);
        tick(0, 0);
        tick(1, 20);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("async_rst_distance", {24'd0, distance}, 0);
        chk("async_rst_dvalid", {31'd0, distance_valid}, 0);
        chk("async_rst_stale", {31'd0, stale}, 0);
        @(negedge clock);
        check_outputs();
        resetn = 1'b1;
        tick(0, 0);
        chk("lost_update", {31'd0, distance_valid}, 0);

        // Random traffic with occasional long silences
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < TMO + 3; k++) tick(0, 0);
            end else if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 2) == 0) tick(1, int'($urandom_range(0, 255)));
                else tick(1, m_dist + int'($urandom_range(0, 60)) - 30 < 0 ? 0 : m_dist + int'($urandom_range(0, 30)));
            end else begin
                tick(0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
